// File: rtl/udlx_fetch_pkg.sv
// Shared types and constants for the uDLX fetch-stage PC sequencer.
package udlx_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        REDIR
    } fetch_state_e;

    localparam int PC_INCR = 4;

    // Clears the byte offset inside a 32-bit instruction word.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_redirect_reg.sv
// Pending redirect target register with misaligned-target detection.
module fetch_redirect_reg
    import udlx_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] new_pc,
    output logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pending_pc,
    output logic                misalign
);

    logic [PC_WIDTH-1:0] pending_p1;
    logic                misalign_p1;

    assign target = new_pc & WORD_ALIGN_MASK[PC_WIDTH-1:0];

    // Stage p1: captured target and the misalignment pulse for this redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_p1  <= '0;
            misalign_p1 <= 1'b0;
        end else begin
            misalign_p1 <= load & (|new_pc[1:0]);
            if (load) begin
                pending_p1 <= target;
            end
        end
    end

    assign pending_pc = pending_p1;
    assign misalign   = misalign_p1;

endmodule

// File: rtl/fetch_pc_control.sv
// uDLX fetch PC sequencer: PC register, imem request FSM, wrong-path squash, flushes.
// Optional macro UDLX_DELAY_SLOT_EN keeps the delay-slot instruction in ID alive on redirect.
module fetch_pc_control
    import udlx_fetch_pkg::*;
#(
    parameter int                   PC_WIDTH = 20,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                select_new_pc_in,
    input  logic [PC_WIDTH-1:0] new_pc_in,
    input  logic                imem_ready_in,
    output logic                imem_req_out,
    output logic [PC_WIDTH-1:0] imem_addr_out,
    output logic                inst_valid_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                flush_if_id_out,
    output logic                flush_id_ex_out,
    output logic                misalign_out
);

    fetch_state_e        state, state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc_p0, fetch_pc_nxt;
    logic [PC_WIDTH-1:0] pc_p1;
    logic                vld_p1;
    logic [PC_WIDTH-1:0] target, pending_pc;
    logic                redirect, accept;

    // Redirects are ignored in BOOT; the PC is still being established.
    assign redirect = select_new_pc_in & (state != BOOT);

    fetch_redirect_reg #(.PC_WIDTH(PC_WIDTH)) u_redirect (
        .clk        (clk),
        .rst        (rst),
        .load       (redirect),
        .new_pc     (new_pc_in),
        .target     (target),
        .pending_pc (pending_pc),
        .misalign   (misalign_out)
    );

    assign imem_req_out  = (state == RUN) || (state == REDIR);
    assign imem_addr_out = (state == REDIR) ? pending_pc : fetch_pc_p0;
    assign accept        = imem_req_out & imem_ready_in;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc_p0;
        case (state)
            BOOT:  state_nxt = RUN;
            RUN: begin
                if (accept) fetch_pc_nxt = fetch_pc_p0 + PC_WIDTH'(PC_INCR);
                if (stall_in) state_nxt = HOLD;
            end
            HOLD: begin
                if (!stall_in) state_nxt = RUN;
            end
            REDIR: begin
                if (accept) begin
                    fetch_pc_nxt = pending_pc + PC_WIDTH'(PC_INCR);
                    state_nxt    = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
        // A redirect under stall parks in REDIR so the target request survives the stall.
        if (redirect) begin
            fetch_pc_nxt = target;
            state_nxt    = stall_in ? REDIR : RUN;
        end
    end

    // Stage p0: PC register and sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc_p0 <= RESET_PC;
        end else begin
            state       <= state_nxt;
            fetch_pc_p0 <= fetch_pc_nxt;
        end
    end

    // Stage p1: one-cycle memory latency; the acceptance in a redirect cycle is wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            pc_p1  <= '0;
        end else begin
            vld_p1 <= accept & ~select_new_pc_in;
            if (accept) pc_p1 <= imem_addr_out;
        end
    end

    assign inst_valid_out  = vld_p1;
    assign pc_out          = pc_p1;
    assign flush_if_id_out = select_new_pc_in & ~rst;

`ifdef UDLX_DELAY_SLOT_EN
    assign flush_id_ex_out = 1'b0;
`else
    assign flush_id_ex_out = flush_if_id_out;
`endif

endmodule

// File: tb/tb_fetch_pc_control.sv
// Scoreboard bench for fetch_pc_control (PC_WIDTH=8 so the wrap boundary is reachable).
module tb_fetch_pc_control;

    localparam int PW = 8;
`ifdef UDLX_DELAY_SLOT_EN
    localparam logic EXP_IDEX = 1'b0;
`else
    localparam logic EXP_IDEX = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_in;
    logic          select_new_pc_in;
    logic [PW-1:0] new_pc_in;
    logic          imem_ready_in;
    logic          imem_req_out;
    logic [PW-1:0] imem_addr_out;
    logic          inst_valid_out;
    logic [PW-1:0] pc_out;
    logic          flush_if_id_out;
    logic          flush_id_ex_out;
    logic          misalign_out;

    fetch_pc_control #(.PC_WIDTH(PW), .RESET_PC(8'h00)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .select_new_pc_in (select_new_pc_in),
        .new_pc_in        (new_pc_in),
        .imem_ready_in    (imem_ready_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .inst_valid_out   (inst_valid_out),
        .pc_out           (pc_out),
        .flush_if_id_out  (flush_if_id_out),
        .flush_id_ex_out  (flush_id_ex_out),
        .misalign_out     (misalign_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  v;
    } ev_t;

    ev_t exp_acc[$];
    ev_t exp_inst[$];
    ev_t exp_flush[$];
    ev_t exp_mis[$];
    int  exp_rst[$];

    int n_total = 0;
    int n_pass  = 0;
    bit mon_on  = 1'b0;

    task automatic check(input string nm, input int act_c, input int req_c,
                         input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act_c != req_c || act !== req) begin
            $display("FAIL %s: got cycle %0d value %h, required cycle %0d value %h",
                     nm, act_c, act, req_c, req);
        end else begin
            n_pass++;
        end
    endtask

    task automatic unexpected(input string nm, input logic [7:0] act);
        n_total++;
        $display("FAIL %s: unexpected event at cycle %0d value %h, required none", nm, cyc, act);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (mon_on) begin
            ev_t e;
            if (exp_rst.size() > 0 && exp_rst[0] == cyc) begin
                void'(exp_rst.pop_front());
                check("rst_req",      cyc, cyc, {7'd0, imem_req_out},    8'h00);
                check("rst_addr",     cyc, cyc, imem_addr_out,           8'h00);
                check("rst_valid",    cyc, cyc, {7'd0, inst_valid_out},  8'h00);
                check("rst_pc",       cyc, cyc, pc_out,                  8'h00);
                check("rst_flush",    cyc, cyc, {6'd0, flush_if_id_out, flush_id_ex_out}, 8'h00);
                check("rst_misalign", cyc, cyc, {7'd0, misalign_out},    8'h00);
            end
            if (imem_req_out === 1'b1 && imem_ready_in === 1'b1) begin
                if (exp_acc.size() == 0) unexpected("accept", imem_addr_out);
                else begin
                    e = exp_acc.pop_front();
                    check("accept", cyc, e.c, imem_addr_out, e.v);
                end
            end
            if (inst_valid_out === 1'b1) begin
                if (exp_inst.size() == 0) unexpected("inst_valid", pc_out);
                else begin
                    e = exp_inst.pop_front();
                    check("inst_pc", cyc, e.c, pc_out, e.v);
                end
            end
            if (flush_if_id_out === 1'b1) begin
                if (exp_flush.size() == 0) unexpected("flush", {7'd0, flush_id_ex_out});
                else begin
                    e = exp_flush.pop_front();
                    check("flush_id_ex", cyc, e.c, {7'd0, flush_id_ex_out}, e.v);
                end
            end else if (flush_id_ex_out === 1'b1) begin
                unexpected("flush_id_ex_alone", 8'h01);
            end
            if (misalign_out === 1'b1) begin
                if (exp_mis.size() == 0) unexpected("misalign", 8'h01);
                else begin
                    e = exp_mis.pop_front();
                    check("misalign", cyc, e.c, 8'h01, e.v);
                end
            end
        end
    end

    function automatic ev_t mk(input int c, input logic [7:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        return e;
    endfunction

    task automatic drive(input logic r, input logic s, input logic sel,
                         input logic [7:0] npc, input logic rdy);
        rst = r; stall_in = s; select_new_pc_in = sel; new_pc_in = npc; imem_ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        rst = 1'b1; stall_in = 1'b0; select_new_pc_in = 1'b0;
        new_pc_in = '0; imem_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_rst.push_back(cyc);
        mon_on = 1'b1;

        // Reset release, sequential fetch, then a 3-cycle stall.
        b = cyc;
        exp_acc.push_back(mk(b+1, 8'h00)); exp_acc.push_back(mk(b+2, 8'h04));
        exp_acc.push_back(mk(b+3, 8'h08)); exp_acc.push_back(mk(b+4, 8'h0C));
        exp_acc.push_back(mk(b+8, 8'h10)); exp_acc.push_back(mk(b+9, 8'h14));
        exp_inst.push_back(mk(b+2, 8'h00)); exp_inst.push_back(mk(b+3, 8'h04));
        exp_inst.push_back(mk(b+4, 8'h08)); exp_inst.push_back(mk(b+5, 8'h0C));
        exp_inst.push_back(mk(b+9, 8'h10)); exp_inst.push_back(mk(b+10, 8'h14));
        repeat (4) drive(0, 0, 0, 8'h00, 1);
        repeat (3) drive(0, 1, 0, 8'h00, 1);
        repeat (3) drive(0, 0, 0, 8'h00, 1);

        // Redirect to 0x40 with memory ready.
        b = cyc;
        exp_acc.push_back(mk(b, 8'h18)); exp_flush.push_back(mk(b, {7'd0, EXP_IDEX}));
        exp_acc.push_back(mk(b+1, 8'h40)); exp_acc.push_back(mk(b+2, 8'h44));
        exp_inst.push_back(mk(b+2, 8'h40)); exp_inst.push_back(mk(b+3, 8'h44));
        drive(0, 0, 1, 8'h40, 1);
        repeat (2) drive(0, 0, 0, 8'h00, 1);

        // Redirect to 0x80 under stall with memory busy for 2 cycles.
        b = cyc;
        exp_flush.push_back(mk(b, {7'd0, EXP_IDEX}));
        exp_acc.push_back(mk(b+2, 8'h80)); exp_acc.push_back(mk(b+3, 8'h84));
        exp_inst.push_back(mk(b+3, 8'h80)); exp_inst.push_back(mk(b+4, 8'h84));
        drive(0, 1, 1, 8'h80, 0);
        drive(0, 1, 0, 8'h00, 0);
        drive(0, 1, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Misaligned redirect target 0x43.
        b = cyc;
        exp_acc.push_back(mk(b, 8'h88)); exp_flush.push_back(mk(b, {7'd0, EXP_IDEX}));
        exp_mis.push_back(mk(b+1, 8'h01));
        exp_acc.push_back(mk(b+1, 8'h40)); exp_acc.push_back(mk(b+2, 8'h44));
        exp_inst.push_back(mk(b+2, 8'h40)); exp_inst.push_back(mk(b+3, 8'h44));
        drive(0, 0, 1, 8'h43, 1);
        repeat (2) drive(0, 0, 0, 8'h00, 1);

        // Wrap at the top of the address space.
        b = cyc;
        exp_acc.push_back(mk(b, 8'h48)); exp_flush.push_back(mk(b, {7'd0, EXP_IDEX}));
        exp_acc.push_back(mk(b+1, 8'hF8)); exp_acc.push_back(mk(b+2, 8'hFC));
        exp_acc.push_back(mk(b+3, 8'h00));
        exp_inst.push_back(mk(b+2, 8'hF8)); exp_inst.push_back(mk(b+3, 8'hFC));
        exp_inst.push_back(mk(b+4, 8'h00));
        drive(0, 0, 1, 8'hF8, 1);
        repeat (3) drive(0, 0, 0, 8'h00, 1);

        // Park in REDIR, then reset: pending target must be dropped.
        b = cyc;
        exp_acc.push_back(mk(b, 8'h04)); exp_flush.push_back(mk(b, {7'd0, EXP_IDEX}));
        exp_rst.push_back(b+2);
        exp_acc.push_back(mk(b+4, 8'h00)); exp_acc.push_back(mk(b+5, 8'h04));
        exp_inst.push_back(mk(b+5, 8'h00)); exp_inst.push_back(mk(b+6, 8'h04));
        drive(0, 1, 1, 8'h20, 1);
        drive(1, 0, 1, 8'h30, 0);
        drive(1, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        repeat (5) drive(0, 1, 0, 8'h00, 1);

        mon_on = 1'b0;
        foreach (exp_acc[i])   begin n_total++; $display("FAIL accept_missing: got none, required cycle %0d addr %h", exp_acc[i].c, exp_acc[i].v); end
        foreach (exp_inst[i])  begin n_total++; $display("FAIL inst_missing: got none, required cycle %0d pc %h", exp_inst[i].c, exp_inst[i].v); end
        foreach (exp_flush[i]) begin n_total++; $display("FAIL flush_missing: got none, required cycle %0d", exp_flush[i].c); end
        foreach (exp_mis[i])   begin n_total++; $display("FAIL misalign_missing: got none, required cycle %0d", exp_mis[i].c); end
        foreach (exp_rst[i])   begin n_total++; $display("FAIL rst_missing: got none, required cycle %0d", exp_rst[i]); end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
